// File: rtl/mem_wr_arbiter_pkg.sv
// Shared defaults and round-robin helper for the dual-port write arbiter.
package mem_wr_arbiter_pkg;

    localparam int NREQ_DEF = 3;
    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 4;

    // Pointer is sized for the largest supported requester count (4).
    localparam int PTR_W = 2;
    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t rr_next(input ptr_t last, input int nreq);
        ptr_t nxt;
        if ((int'(last) + 32'sd1) >= nreq) begin
            nxt = 2'd0;
        end else begin
            nxt = last + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_wr_arbiter_mem.sv
// Storage array with two write ports and one read port; the read port sees
// same-cycle writes so the caller never observes a stale entry.
module mem_2w1r_fwd
    import mem_wr_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          we2,
    input  logic [AW-1:0] wa2,
    input  logic [DW-1:0] wd2,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next array contents: both ports may write, addresses are never equal.
    always_comb begin
        mem_d = mem_q;
        if (we1) begin
            mem_d[wa1] = wd1;
        end else begin
        end
        if (we2) begin
            mem_d[wa2] = wd2;
        end else begin
        end
    end

    // Array storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read with forwarding from whichever write port hits the read address.
    always_comb begin
        if (we1 && (wa1 == ra)) begin
            rdata = wd1;
        end else if (we2 && (wa2 == ra)) begin
            rdata = wd2;
        end else begin
            rdata = mem_q[ra];
        end
    end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter granting up to two distinct-address writes per cycle
// into a shared array, plus a one-cycle registered read pipeline.
module mem_wr_arbiter
    import mem_wr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid
);

    logic [AW-1:0]   addr_s [NREQ];
    logic [DW-1:0]   data_s [NREQ];
    logic [NREQ-1:0] ready_s;
    ptr_t            scan_idx_s;
    logic            p1_found_s;
    logic            p2_seen_s;
    logic            p2_en_s;
    ptr_t            p1_idx_s;
    ptr_t            p2_idx_s;
    logic [AW-1:0]   p1_addr_s;
    logic [AW-1:0]   p2_addr_s;
    logic [DW-1:0]   p1_data_s;
    logic [DW-1:0]   p2_data_s;
    logic [DW-1:0]   rd_fwd_s;

    ptr_t            rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    // Unpack the per-requester address and data lanes.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_s[i] = req_addr[i*AW +: AW];
            data_s[i] = req_data[i*DW +: DW];
        end
    end

    // Circular scan from rr_ptr: first valid takes P1, the next valid takes P2
    // only when its address differs; later requesters wait regardless.
    always_comb begin
        ready_s    = {NREQ{1'b0}};
        scan_idx_s = 2'd0;
        p1_found_s = 1'b0;
        p2_seen_s  = 1'b0;
        p2_en_s    = 1'b0;
        p1_idx_s   = 2'd0;
        p2_idx_s   = 2'd0;
        p1_addr_s  = {AW{1'b0}};
        p2_addr_s  = {AW{1'b0}};
        p1_data_s  = {DW{1'b0}};
        p2_data_s  = {DW{1'b0}};
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx_s = ptr_t'((int'(rr_ptr_q) + k) % NREQ);
                if (req_valid[scan_idx_s]) begin
                    if (!p1_found_s) begin
                        p1_found_s          = 1'b1;
                        p1_idx_s            = scan_idx_s;
                        p1_addr_s           = addr_s[scan_idx_s];
                        p1_data_s           = data_s[scan_idx_s];
                        ready_s[scan_idx_s] = 1'b1;
                    end else if (!p2_seen_s) begin
                        p2_seen_s = 1'b1;
                        if (addr_s[scan_idx_s] != p1_addr_s) begin
                            p2_en_s             = 1'b1;
                            p2_idx_s            = scan_idx_s;
                            p2_addr_s           = addr_s[scan_idx_s];
                            p2_data_s           = data_s[scan_idx_s];
                            ready_s[scan_idx_s] = 1'b1;
                        end else begin
                        end
                    end else begin
                    end
                end else begin
                end
            end
        end else begin
        end
    end

    assign req_ready = ready_s;

    // Pointer moves past the last granted requester, read pipeline captures.
    always_comb begin
        if (p2_en_s) begin
            rr_ptr_d = rr_next(p2_idx_s, NREQ);
        end else if (p1_found_s) begin
            rr_ptr_d = rr_next(p1_idx_s, NREQ);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (rd_en) begin
            rd_data_d = rd_fwd_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = rd_en;
    end

    // Arbiter pointer and read output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= 2'd0;
            rd_data_q  <= {DW{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    mem_2w1r_fwd #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we1   (p1_found_s),
        .wa1   (p1_addr_s),
        .wd1   (p1_data_s),
        .we2   (p2_en_s),
        .wa2   (p2_addr_s),
        .wd2   (p2_data_s),
        .ra    (rd_addr),
        .rdata (rd_fwd_s)
    );

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Scoreboard bench: a list-based arbitration model predicts grants and read
// results; a negedge monitor consumes expected read data as rd_valid appears.
module tb_mem_wr_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 4;
    localparam int DW   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_mem [16];
    int            m_ptr = 0;
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] mon_e;
    bit            rst_at_edge = 1'b1;

    logic [NREQ-1:0] v;
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];
    logic [NREQ-1:0] g;

    mem_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_at_edge <= rst;

    // Monitor: reset clears outputs, rd_valid consumes one expectation,
    // otherwise rd_data must hold the last read value.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
            chk("rst_rd_data", {28'd0, rd_data}, 32'd0);
            last_rd = '0;
        end else if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", {28'd0, rd_data}, {28'd0, mon_e});
                last_rd = mon_e;
            end
        end else begin
            chk("rd_hold", {28'd0, rd_data}, {28'd0, last_rd});
        end
    end

    // One cycle: drive inputs, check grants against the model, update model.
    task automatic step(input bit r, input bit re, input logic [AW-1:0] ra,
                        output logic [NREQ-1:0] gnt);
        int order [$];
        logic [DW-1:0] rexp;
        @(posedge clk);
        #1;
        rst       = r;
        rd_en     = re;
        rd_addr   = ra;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
        @(negedge clk);
        gnt = '0;
        if (!r) begin
            for (int k = 0; k < NREQ; k++) begin
                if (v[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
            end
        end
        if (order.size() >= 1) gnt[order[0]] = 1'b1;
        if (order.size() >= 2 && a[order[1]] != a[order[0]]) gnt[order[1]] = 1'b1;
        chk("req_ready", {29'd0, req_ready}, {29'd0, gnt});
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_ptr = 0;
        end else begin
            if (re) begin
                rexp = m_mem[ra];
                for (int i = 0; i < NREQ; i++) if (gnt[i] && a[i] == ra) rexp = d[i];
                exp_q.push_back(rexp);
            end
            for (int i = 0; i < NREQ; i++) if (gnt[i]) m_mem[a[i]] = d[i];
            if (order.size() >= 2 && gnt[order[1]]) m_ptr = (order[1] + 1) % NREQ;
            else if (order.size() >= 1) m_ptr = (order[0] + 1) % NREQ;
        end
    endtask

    initial begin
        int cnt;
        v = '0;
        foreach (a[i]) begin a[i] = '0; d[i] = '0; end
        foreach (m_mem[i]) m_mem[i] = '0;

        step(1'b1, 1'b0, 4'd0, g);
        step(1'b1, 1'b0, 4'd0, g);

        // Read right after reset returns zero.
        step(1'b0, 1'b1, 4'd5, g);
        step(1'b0, 1'b0, 4'd0, g);

        // Two distinct-address grants, requester 2 left waiting.
        v = 3'b111; a[0] = 4'd3; d[0] = 4'hA; a[1] = 4'd7; d[1] = 4'hB; a[2] = 4'd1; d[2] = 4'h5;
        step(1'b0, 1'b0, 4'd0, g);
        chk("two_grants", {29'd0, g}, 32'd3);
        v = '0;
        step(1'b0, 1'b1, 4'd3, g);
        step(1'b0, 1'b1, 4'd7, g);

        // Same-address contention held until accepted: one grant per cycle.
        step(1'b1, 1'b0, 4'd0, g);
        v = 3'b111; a[0] = 4'd9; a[1] = 4'd9; a[2] = 4'd9; d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3;
        cnt = 0;
        while (v != '0 && cnt < 6) begin
            step(1'b0, 1'b0, 4'd0, g);
            v = v & ~g;
            cnt++;
        end
        chk("hold_cycles", cnt, 32'd3);
        step(1'b0, 1'b1, 4'd9, g);

        // Write and read of the same address in one cycle forwards.
        v = 3'b010; a[1] = 4'd4; d[1] = 4'hC;
        step(1'b0, 1'b1, 4'd4, g);
        v = '0;
        step(1'b0, 1'b0, 4'd0, g);

        // Reset while all requesters are valid, then restart from requester 0.
        v = 3'b111; a[0] = 4'd1; a[1] = 4'd2; a[2] = 4'd3; d[0] = 4'h6; d[1] = 4'h7; d[2] = 4'h8;
        step(1'b0, 1'b0, 4'd0, g);
        step(1'b1, 1'b1, 4'd2, g);
        step(1'b0, 1'b1, 4'd3, g);
        chk("post_rst_grant", {29'd0, g}, 32'd3);

        // Lone requester 2 granted every cycle; pointer wraps back to 0.
        step(1'b1, 1'b0, 4'd0, g);
        v = 3'b100; a[2] = 4'd12;
        for (int i = 0; i < 4; i++) begin
            d[2] = DW'(i + 1);
            step(1'b0, 1'b0, 4'd0, g);
        end
        v = 3'b011; a[0] = 4'd13; a[1] = 4'd14;
        step(1'b0, 1'b1, 4'd12, g);

        // Randomized traffic with address collisions and occasional reset.
        for (int n = 0; n < 400; n++) begin
            v = NREQ'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                a[i] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
                d[i] = DW'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                 AW'($urandom_range(0, 15)), g);
        end

        v = '0;
        step(1'b0, 1'b0, 4'd0, g);
        step(1'b0, 1'b0, 4'd0, g);
        step(1'b0, 1'b0, 4'd0, g);
        chk("drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
